// File: rtl/altsyncram_pkg.sv
// Shared constants and types for the altsyncram replacement.
// Defaults match the video block's 16-bit x 16K VRAM wrapper.
package altsyncram_pkg;

  localparam int DEF_WIDTHAD   = 14;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_BYTE_SIZE = 8;
  localparam int DEF_NUMWORDS  = 16384;

  // Number of byte lanes in a word.
  function automatic int lanes(input int width, input int byte_size);
    return width / byte_size;
  endfunction

  localparam int DEF_LANES = lanes(DEF_WIDTH, DEF_BYTE_SIZE);

  // Default-sized word viewed as byte lanes.
  typedef logic [DEF_LANES-1:0][DEF_BYTE_SIZE-1:0] word_t;

endpackage

// File: rtl/altsyncram_lane.sv
// One byte-lane slice of the RAM: NUMWORDS x BYTE_SIZE storage with its
// own write enable and an unregistered read of the addressed entry.
// Ports:
//   clk      - rising-edge clock
//   we       - lane write enable (already qualified by reset/enable/range)
//   wr_addr  - write address
//   wr_data  - lane write data
//   rd_addr  - read address (caller guards out-of-range)
//   rd_data  - current contents at rd_addr (pre-write on a colliding edge)
module altsyncram_lane #(
  parameter int WIDTHAD   = 14,
  parameter int NUMWORDS  = 16384,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [WIDTHAD-1:0]   wr_addr,
  input  logic [BYTE_SIZE-1:0] wr_data,
  input  logic [WIDTHAD-1:0]   rd_addr,
  output logic [BYTE_SIZE-1:0] rd_data
);

  // No reset on the array: contents survive reset_n. The array powers up
  // zero (block-RAM default contents / simulator zero-init).
  logic [BYTE_SIZE-1:0] mem [NUMWORDS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/altsyncram.sv
// Simple dual-port synchronous RAM: write port A with byte enables, read
// port B, one clock. Drop-in for the vendor altsyncram primitive.
// Ports:
//   clock0     - clock, rising edge
//   reset_n    - async active-low reset; clears read/output regs only
//   clocken0   - global clock enable
//   address_a  - write address      data_a - write data
//   wren_a     - write enable       byteena_a - per-lane write enables
//   address_b  - read address       rden_b - read enable
//   q_b        - read data (latency 1, or 2 with OUTDATA_REG_B)
module altsyncram
  import altsyncram_pkg::*;
#(
  parameter int WIDTHAD       = DEF_WIDTHAD,
  parameter int NUMWORDS      = DEF_NUMWORDS,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int BYTE_SIZE     = DEF_BYTE_SIZE,
  parameter int WIDTH_BYTEENA = lanes(WIDTH, BYTE_SIZE),
  parameter int OUTDATA_REG_B = 0,
  parameter int RDW_NEW_DATA  = 0
) (
  input  logic                     clock0,
  input  logic                     reset_n,
  input  logic                     clocken0,
  input  logic [WIDTHAD-1:0]       address_a,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     wren_a,
  input  logic [WIDTH_BYTEENA-1:0] byteena_a,
  input  logic [WIDTHAD-1:0]       address_b,
  input  logic                     rden_b,
  output logic [WIDTH-1:0]         q_b
);

  // Range checks done one bit wider so NUMWORDS == 2**WIDTHAD fits.
  localparam logic [WIDTHAD:0] NW = NUMWORDS[WIDTHAD:0];

  logic a_ok, b_ok, wr_go, coll;
  assign a_ok  = {1'b0, address_a} < NW;
  assign b_ok  = {1'b0, address_b} < NW;
  // Writes are blocked while reset_n is low.
  assign wr_go = reset_n & clocken0 & wren_a & a_ok;
  assign coll  = (address_a == address_b);

  logic [WIDTH_BYTEENA-1:0][BYTE_SIZE-1:0] wr_lanes, old_lanes, rd_lanes;
  logic [WIDTH_BYTEENA-1:0]                lane_we;
  assign wr_lanes = data_a;

  genvar i;
  generate
    for (i = 0; i < WIDTH_BYTEENA; i++) begin : g_lane
      assign lane_we[i] = wr_go & byteena_a[i];

      altsyncram_lane #(
        .WIDTHAD  (WIDTHAD),
        .NUMWORDS (NUMWORDS),
        .BYTE_SIZE(BYTE_SIZE)
      ) u_lane (
        .clk    (clock0),
        .we     (lane_we[i]),
        .wr_addr(address_a),
        .wr_data(wr_lanes[i]),
        .rd_addr(address_b),
        .rd_data(old_lanes[i])
      );

      // Collision mux: with new-data mode a lane being written to the read
      // address forwards the incoming byte; other lanes keep old contents.
      if (RDW_NEW_DATA != 0) begin : g_fwd
        assign rd_lanes[i] = (lane_we[i] && coll) ? wr_lanes[i] : old_lanes[i];
      end else begin : g_old
        assign rd_lanes[i] = old_lanes[i];
      end
    end
  endgenerate

  logic [WIDTH-1:0] rd_next, rd_q;
  assign rd_next = b_ok ? rd_lanes : '0;

  always_ff @(posedge clock0 or negedge reset_n) begin
    if (!reset_n)                rd_q <= '0;
    else if (clocken0 && rden_b) rd_q <= rd_next;
  end

  generate
    if (OUTDATA_REG_B != 0) begin : g_oreg
      logic [WIDTH-1:0] out_q;
      always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n)      out_q <= '0;
        else if (clocken0) out_q <= rd_q;
      end
      assign q_b = out_q;
    end else begin : g_noreg
      assign q_b = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_altsyncram.sv
// Self-checking bench for altsyncram at default parameters (latency 1,
// old-data collision). Directed vector table, hand sequences for reset and
// clock-enable, then random traffic against a word-level reference model.
module tb_altsyncram;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int NW = 16384;
  localparam int RDW_NEW = 0;

  logic          clock0 = 1'b0;
  logic          reset_n;
  logic          clocken0;
  logic [AW-1:0] address_a;
  logic [DW-1:0] data_a;
  logic          wren_a;
  logic [1:0]    byteena_a;
  logic [AW-1:0] address_b;
  logic          rden_b;
  logic [DW-1:0] q_b;

  altsyncram dut (
    .clock0   (clock0),
    .reset_n  (reset_n),
    .clocken0 (clocken0),
    .address_a(address_a),
    .data_a   (data_a),
    .wren_a   (wren_a),
    .byteena_a(byteena_a),
    .address_b(address_b),
    .rden_b   (rden_b),
    .q_b      (q_b)
  );

  always #5 clock0 = ~clock0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word array and the value q_b should show.
  logic [DW-1:0] m_mem [NW];
  logic [DW-1:0] m_q;

  typedef struct {
    bit            wr;
    logic [AW-1:0] aa;
    logic [DW-1:0] d;
    logic [1:0]    be;
    bit            rd;
    logic [AW-1:0] ab;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q_b=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit ce, input bit wr, input logic [AW-1:0] aa, input logic [DW-1:0] d,
                       input logic [1:0] be, input bit rd, input logic [AW-1:0] ab);
    clocken0 = ce; wren_a = wr; address_a = aa; data_a = d;
    byteena_a = be; rden_b = rd; address_b = ab;
  endtask

  // One rising edge as seen by the model (reset_n assumed high).
  task automatic model_edge(input bit ce, input bit wr, input logic [AW-1:0] aa, input logic [DW-1:0] d,
                            input logic [1:0] be, input bit rd, input logic [AW-1:0] ab);
    logic [DW-1:0] old_w, mask;
    old_w = (int'(ab) < NW) ? m_mem[ab] : '0;
    mask  = {{8{be[1]}}, {8{be[0]}}};
    if (ce && wr && int'(aa) < NW) m_mem[aa] = (m_mem[aa] & ~mask) | (d & mask);
    if (ce && rd) m_q = (RDW_NEW != 0 && int'(ab) < NW) ? m_mem[ab] : old_w;
  endtask

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NW; k++) m_mem[k] = '0;
    m_q = '0;

    //           wr aa        d         be    rd ab        exp (after edge)
    tbl[0]  = '{1, 14'h0010, 16'hA55A, 2'b11, 0, 14'h0000, 16'h0000};
    tbl[1]  = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0010, 16'hA55A};
    tbl[2]  = '{1, 14'h0010, 16'h1234, 2'b01, 1, 14'h0010, 16'hA55A};
    tbl[3]  = '{1, 14'h0010, 16'hCD00, 2'b10, 1, 14'h0010, 16'hA534};
    tbl[4]  = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0010, 16'hCD34};
    tbl[5]  = '{1, 14'h0020, 16'h1111, 2'b11, 0, 14'h0020, 16'hCD34};
    tbl[6]  = '{1, 14'h0020, 16'h2222, 2'b11, 1, 14'h0020, 16'h1111};
    tbl[7]  = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0020, 16'h2222};
    tbl[8]  = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h3FFF, 16'h0000};
    tbl[9]  = '{1, 14'h3FFF, 16'hBEEF, 2'b11, 1, 14'h0000, 16'h0000};
    tbl[10] = '{1, 14'h0000, 16'hF00D, 2'b11, 1, 14'h3FFF, 16'hBEEF};
    tbl[11] = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0000, 16'hF00D};
    tbl[12] = '{1, 14'h0040, 16'h5555, 2'b00, 1, 14'h0040, 16'h0000};
    tbl[13] = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0010, 16'hCD34};
    tbl[14] = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0040, 16'h0000};
    tbl[15] = '{0, 14'h0000, 16'h0000, 2'b00, 1, 14'h0010, 16'hCD34};

    // Reset state
    reset_n = 1'b0;
    drive(1, 0, '0, '0, 2'b00, 0, '0);
    step(); step();
    check("reset_state", q_b, 16'h0000);
    #2 reset_n = 1'b1;

    // Directed table
    for (int k = 0; k < 16; k++) begin
      drive(1, tbl[k].wr, tbl[k].aa, tbl[k].d, tbl[k].be, tbl[k].rd, tbl[k].ab);
      step();
      model_edge(1, tbl[k].wr, tbl[k].aa, tbl[k].d, tbl[k].be, tbl[k].rd, tbl[k].ab);
      check($sformatf("vec%0d", k), q_b, tbl[k].exp);
    end

    // rden_b=0 while address_b moves: q_b holds CD34
    drive(1, 0, '0, '0, 2'b00, 0, 14'h0020);
    step();
    model_edge(1, 0, '0, '0, 2'b00, 0, 14'h0020);
    check("rden_hold", q_b, 16'hCD34);

    // Async reset mid-cycle with q_b nonzero
    #3 reset_n = 1'b0;
    #1 check("async_reset", q_b, 16'h0000);
    m_q = '0;
    // Write attempted during reset must be lost
    drive(1, 1, 14'h0030, 16'h9999, 2'b11, 1, 14'h0010);
    step();
    check("reset_hold", q_b, 16'h0000);
    #2 reset_n = 1'b1;
    drive(1, 0, '0, '0, 2'b00, 1, 14'h0030);
    step();
    model_edge(1, 0, '0, '0, 2'b00, 1, 14'h0030);
    check("reset_write_lost", q_b, 16'h0000);
    drive(1, 0, '0, '0, 2'b00, 1, 14'h0010);
    step();
    model_edge(1, 0, '0, '0, 2'b00, 1, 14'h0010);
    check("mem_survives_reset", q_b, 16'hCD34);

    // clocken0=0: no write, q_b frozen
    drive(0, 1, 14'h0030, 16'h7777, 2'b11, 1, 14'h0020);
    step();
    model_edge(0, 1, 14'h0030, 16'h7777, 2'b11, 1, 14'h0020);
    check("ce_freeze", q_b, 16'hCD34);
    drive(1, 0, '0, '0, 2'b00, 1, 14'h0030);
    step();
    model_edge(1, 0, '0, '0, 2'b00, 1, 14'h0030);
    check("ce_no_write", q_b, 16'h0000);

    // Random traffic on a small address pool to force collisions
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] pool [6];
      bit ce, wr, rd;
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] d;
      logic [1:0] be;
      pool = '{14'h0000, 14'h0001, 14'h0010, 14'h0020, 14'h2000, 14'h3FFF};
      ce = ($urandom % 8) != 0;
      wr = $urandom % 2;
      rd = ($urandom % 4) != 0;
      aa = ($urandom % 8 == 0) ? AW'($urandom) : pool[$urandom % 6];
      ab = ($urandom % 8 == 0) ? AW'($urandom) : pool[$urandom % 6];
      d  = DW'($urandom);
      be = 2'($urandom);
      drive(ce, wr, aa, d, be, rd, ab);
      step();
      model_edge(ce, wr, aa, d, be, rd, ab);
      check($sformatf("rand%0d", k), q_b, m_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/altsyncram.md
Name: altsyncram

Overview:
- Simple dual-port synchronous RAM with one write port (A) and one read port (B), both on a single clock.
- Port A has per-byte write enables.
- Holds the frame buffer behind the video block's 16-bit-wide, 14-bit-address VRAM wrapper.
- This block replaces the vendor primitive when that primitive is unavailable; the video path consumes q_b one clock after address_b is sampled.

Parameters:
- WIDTHAD, 14, address width of both ports.
- NUMWORDS, 16384, number of words implemented (must be no greater than 2**WIDTHAD).
- WIDTH, 16, data width of both ports.
- BYTE_SIZE, 8, bits per byte lane; WIDTH must be a multiple of BYTE_SIZE.
- WIDTH_BYTEENA, WIDTH/BYTE_SIZE (2), number of byte lanes.
- OUTDATA_REG_B, 0, 0 = read latency 1 clock; 1 = extra output register, read latency 2 clocks.
- RDW_NEW_DATA, 0, mixed-port read-during-write result: 0 = old data, 1 = newly written (byte-merged) data.

Ports:
- clock0  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clocken0  in  1  global clock enable; when 0, no state changes.
- address_a  in  WIDTHAD  write address.
- data_a  in  WIDTH  write data.
- wren_a  in  1  write enable.
- byteena_a  in  WIDTH_BYTEENA  byte-lane enables; bit i covers data_a[i*BYTE_SIZE +: BYTE_SIZE].
- address_b  in  WIDTHAD  read address.
- rden_b  in  1  read enable.
- q_b  out  WIDTH  read data.

Behaviour:
- Memory array: NUMWORDS x WIDTH.
  - Contents are all zeros at power-up (initial).
  - Contents are NOT cleared by reset.
- Reset (reset_n low, asynchronous):
  - The read-data register, and the output register if present, clear to 0, so q_b = 0.
  - Writes are suppressed while reset_n is low.
  - Reset may assert mid-operation; the first write/read takes effect on the first rising edge with reset_n high.
- Write:
  - Condition: rising clock0 with clocken0=1, wren_a=1 and address_a < NUMWORDS.
  - For each lane i with byteena_a[i]=1, that lane is written from data_a; lanes with byteena_a[i]=0 keep their old value.
  - byteena_a=0 is a no-op.
  - address_a >= NUMWORDS: the write is ignored.
- Read:
  - Condition: rising clock0 with clocken0=1 and rden_b=1.
  - The read register loads mem[address_b]; address_b >= NUMWORDS loads 0.
  - With OUTDATA_REG_B=0, q_b is the read register: latency 1 clock.
  - With OUTDATA_REG_B=1, a second register (also gated by clocken0) follows: latency 2 clocks.
  - rden_b=0 or clocken0=0: registers hold their value.
- Mixed-port collision (same edge, address_a == address_b, write active):
  - RDW_NEW_DATA=0: read returns pre-write word.
  - RDW_NEW_DATA=1: read returns the word after byte merge.
- Writes never alter q_b except through a later read.
- All arithmetic is unsigned; address comparison is at full WIDTHAD width.

Decomposition:
- Shared package altsyncram_pkg:
  - default constants (WIDTHAD 14, WIDTH 16, BYTE_SIZE 8, NUMWORDS 16384);
  - function computing lane count;
  - word typedef as packed [lanes][BYTE_SIZE].
- Optional single sub-module altsyncram_lane: one BYTE_SIZE-wide memory slice with its own write enable, generated WIDTH_BYTEENA times. The top level holds the read/output registers and the collision mux.
- The body is a generate loop, no further hierarchy.

Test Plan:
- Basic write/read:
  - Stimulus: write 0xA55A to address 0x0010 with byteena=11; next clock, read 0x0010.
  - Response: q_b = 0xA55A one clock after the read address is sampled (two clocks with OUTDATA_REG_B=1).
- Byte enables:
  - Stimulus: after the above, write 0x1234 with byteena=01, then 0xCDxx with byteena=10.
  - Response: word reads 0xA534, then 0xCD34.
- Collision:
  - Stimulus: mem[0x0020]=0x1111; on one edge write 0x2222 to 0x0020 and read 0x0020.
  - Response: q_b = 0x1111 with RDW_NEW_DATA=0, 0x2222 with RDW_NEW_DATA=1; the next read returns 0x2222.
- Reset:
  - Stimulus: q_b nonzero, pulse reset_n low between clock edges.
  - Response: q_b = 0 immediately (asynchronous); memory still holds prior data on the next read.
  - Stimulus: write attempted while reset_n is low.
  - Response: that write is lost.
- Enables:
  - Stimulus: clocken0=0 with wren_a=1 writing to 0x0030.
  - Response: no write; q_b frozen.
  - Stimulus: rden_b=0 while address_b changes.
  - Response: q_b holds.
- Power-up and edge addresses:
  - Stimulus: read 0x3FFF before any write.
  - Response: 0x0000.
  - Stimulus: write then read 0x3FFF and 0x0000.
  - Response: both return the written values.
